// File: rtl/servo_scan_ctrl.sv
// ---------------------------------------------------------------------------
// servo_scan_ctrl
// Sequences the 3-position ultrasonic-sensor servo (0 = I/left, 1 = C/centre,
// 2 = D/right). GOTO and SCAN commands arrive over a valid/ready handshake
// that is only open in IDLE. Every move is followed by a settle interval, and
// a scan triggers one range measurement per position before returning to C.
//
// Optional feature macro: SERVO_SCAN_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT_CYCLES, stores all-ones, sets scan_err
//   undefined : WAIT blocks until meas_done; scan_err is tied low
// ---------------------------------------------------------------------------
module servo_scan_ctrl #(
    parameter int SETTLE_CYCLES  = 25_000_000,
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int DIST_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_pos,
    output logic [1:0]        pos,
    output logic              meas_start,
    input  logic              meas_done,
    input  logic [DIST_W-1:0] meas_data,
    output logic              busy,
    output logic              done,
    output logic [DIST_W-1:0] dist_i,
    output logic [DIST_W-1:0] dist_c,
    output logic [DIST_W-1:0] dist_d,
    output logic              scan_err
);

    // One counter serves both the settle interval (MOVE) and, when the
    // feature is built in, the measurement timeout (WAIT); it is sized for
    // the larger of the two so the same register works in both builds.
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef SERVO_SCAN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    localparam logic [1:0] OP_GOTO = 2'd0;
    localparam logic [1:0] OP_SCAN = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MOVE = 3'd1,
        S_MEAS = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // state and datapath registers
    state_t            r_state;
    logic [1:0]        r_pos;
    logic [1:0]        r_step;
    logic              r_is_scan;
    logic [CNT_W-1:0]  r_cnt;
    logic [DIST_W-1:0] r_dist_i;
    logic [DIST_W-1:0] r_dist_c;
    logic [DIST_W-1:0] r_dist_d;

    // registered handshake / status outputs
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_meas_start;

    // next-state values
    state_t            w_state_nxt;
    logic [1:0]        w_pos_nxt;
    logic [1:0]        w_step_nxt;
    logic              w_is_scan_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DIST_W-1:0] w_dist_i_nxt;
    logic [DIST_W-1:0] w_dist_c_nxt;
    logic [DIST_W-1:0] w_dist_d_nxt;
    logic              w_wait_exit;
    logic [DIST_W-1:0] w_wait_val;

`ifdef SERVO_SCAN_TIMEOUT_EN
    logic              r_scan_err;
    logic              w_scan_err_nxt;
`endif

    // Next-state and datapath decode; every target starts from its hold value.
    always_comb begin
        w_state_nxt   = r_state;
        w_pos_nxt     = r_pos;
        w_step_nxt    = r_step;
        w_is_scan_nxt = r_is_scan;
        w_cnt_nxt     = CNT_ZERO;
        w_dist_i_nxt  = r_dist_i;
        w_dist_c_nxt  = r_dist_c;
        w_dist_d_nxt  = r_dist_d;
        w_wait_exit   = 1'b0;
        w_wait_val    = meas_data;
`ifdef SERVO_SCAN_TIMEOUT_EN
        w_scan_err_nxt = r_scan_err;
`endif

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    case (cmd_op)
                        OP_GOTO: begin
                            // position code 3 does not exist on the servo; treat it as centre
                            w_pos_nxt     = (cmd_pos == 2'd3) ? 2'd1 : cmd_pos;
                            w_is_scan_nxt = 1'b0;
                            w_state_nxt   = S_MOVE;
                        end
                        OP_SCAN: begin
                            w_pos_nxt     = 2'd0;
                            w_step_nxt    = 2'd0;
                            w_is_scan_nxt = 1'b1;
`ifdef SERVO_SCAN_TIMEOUT_EN
                            w_scan_err_nxt = 1'b0;
`endif
                            w_state_nxt   = S_MOVE;
                        end
                        default: begin
                            // NOP: acknowledge with a done pulse, nothing moves
                            w_state_nxt = S_DONE;
                        end
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_MOVE: begin
                if (r_cnt == SETTLE_LAST) begin
                    // step 3 is the return-to-centre leg of a scan: no measurement
                    if (r_is_scan && (r_step != 2'd3)) begin
                        w_state_nxt = S_MEAS;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    w_state_nxt = S_MOVE;
                end
            end

            S_MEAS: begin
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
`ifdef SERVO_SCAN_TIMEOUT_EN
                // a measurement arriving on the timeout cycle still counts as good data
                if (meas_done) begin
                    w_wait_exit = 1'b1;
                    w_wait_val  = meas_data;
                end else if (r_cnt == TMO_LAST) begin
                    w_wait_exit    = 1'b1;
                    w_wait_val     = {DIST_W{1'b1}};
                    w_scan_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
`else
                if (meas_done) begin
                    w_wait_exit = 1'b1;
                end else begin
                    w_wait_exit = 1'b0;
                end
`endif
                if (w_wait_exit) begin
                    case (r_step)
                        2'd0:    w_dist_i_nxt = w_wait_val;
                        2'd1:    w_dist_c_nxt = w_wait_val;
                        2'd2:    w_dist_d_nxt = w_wait_val;
                        default: w_dist_i_nxt = r_dist_i;
                    endcase
                    if (r_step == 2'd2) begin
                        w_pos_nxt  = 2'd1;
                        w_step_nxt = 2'd3;
                    end else begin
                        w_pos_nxt  = r_step + 2'd1;
                        w_step_nxt = r_step + 2'd1;
                    end
                    w_state_nxt = S_MOVE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Position, scan bookkeeping, shared counter and stored distances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos     <= 2'd1;
            r_step    <= 2'd0;
            r_is_scan <= 1'b0;
            r_cnt     <= CNT_ZERO;
            r_dist_i  <= {DIST_W{1'b0}};
            r_dist_c  <= {DIST_W{1'b0}};
            r_dist_d  <= {DIST_W{1'b0}};
        end else begin
            r_pos     <= w_pos_nxt;
            r_step    <= w_step_nxt;
            r_is_scan <= w_is_scan_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dist_i  <= w_dist_i_nxt;
            r_dist_c  <= w_dist_c_nxt;
            r_dist_d  <= w_dist_d_nxt;
        end
    end

    // Status outputs registered from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_meas_start <= 1'b0;
        end else begin
            r_cmd_ready  <= (w_state_nxt == S_IDLE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_done       <= (w_state_nxt == S_DONE);
            r_meas_start <= (w_state_nxt == S_MEAS);
        end
    end

`ifdef SERVO_SCAN_TIMEOUT_EN
    // Sticky per-scan timeout flag, cleared when a new scan is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_err <= 1'b0;
        end else begin
            r_scan_err <= w_scan_err_nxt;
        end
    end

    assign scan_err = r_scan_err;
`else
    assign scan_err = 1'b0;
`endif

    assign cmd_ready  = r_cmd_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign meas_start = r_meas_start;
    assign pos        = r_pos;
    assign dist_i     = r_dist_i;
    assign dist_c     = r_dist_c;
    assign dist_d     = r_dist_d;

endmodule
